// File: rtl/seg_scan_driver.sv
// Two-group BCD display driver: double-dabble conversion plus eight-digit scan.
// Defining SEG_BLINK_EN adds a blink input and phase counter that can blank the whole display.
module seg_scan_driver #(
  parameter int F_CLK       = 50000000,
  parameter int F_SCAN      = 1000,
  parameter int LZ_SUPPRESS = 1
`ifdef SEG_BLINK_EN
  , parameter int BLINK_HZ  = 2
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] val_a,
  input  logic [7:0] val_b,
  input  logic       load,
  input  logic [7:0] dig_en,
`ifdef SEG_BLINK_EN
  input  logic       blink,
`endif
  output logic       busy,
  output logic [7:0] cs,
  output logic [7:0] o_dig_sel
);
  // state   | meaning
  // ST_IDLE | display stable, load accepted
  // ST_CONV | double-dabble iterating, load ignored
  localparam int DIV   = F_CLK / F_SCAN;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic {ST_IDLE, ST_CONV} state_t;

  state_t           state_q, state_d;
  logic [19:0]      work_a_q, work_a_d, work_b_q, work_b_d;
  logic [19:0]      step_a, step_b;
  logic [2:0]       iter_q, iter_d;
  logic [11:0]      bcd_a_q, bcd_a_d, bcd_b_q, bcd_b_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       cs_q, cs_d, sel_q, sel_d;
  logic [11:0]      grp;
  logic [3:0]       dig;
  logic             blank, dash, disp_on;

  function automatic logic [19:0] dd_step(input logic [19:0] w);
    logic [19:0] t;
    t = w;
    for (int n = 0; n < 3; n++) begin
      if (t[8+4*n +: 4] >= 4'd5) t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign step_a = dd_step(work_a_q);
  assign step_b = dd_step(work_b_q);

  always_comb begin
    state_d  = state_q;
    work_a_d = work_a_q;
    work_b_d = work_b_q;
    iter_d   = iter_q;
    bcd_a_d  = bcd_a_q;
    bcd_b_d  = bcd_b_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d  = ST_CONV;
          work_a_d = {12'd0, val_a};
          work_b_d = {12'd0, val_b};
          iter_d   = 3'd7;
        end
      end
      ST_CONV: begin
        work_a_d = step_a;
        work_b_d = step_b;
        iter_d   = iter_q - 3'd1;
        // Both groups commit together so the display never shows a half-updated pair.
        if (iter_q == 3'd0) begin
          state_d = ST_IDLE;
          bcd_a_d = step_a[19:8];
          bcd_b_d = step_b[19:8];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_CONV);

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    idx_d = (div_q == DIV_LAST) ? idx_q + 3'd1 : idx_q;
  end

`ifdef SEG_BLINK_EN
  localparam int HALF   = F_CLK / (2 * BLINK_HZ);
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

  logic [HALF_W-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q - 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == '0) begin
      blink_cnt_d = HALF_LAST;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= HALF_LAST;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign disp_on = ~blink | phase_q;
`else
  assign disp_on = 1'b1;
`endif

  // Digits 7..5 show group A, 2..0 group B, 4..3 are fixed dashes.
  always_comb begin
    grp   = idx_q[2] ? bcd_a_q : bcd_b_q;
    dash  = (idx_q == 3'd3) || (idx_q == 3'd4);
    dig   = grp[3:0];
    blank = 1'b0;
    case (idx_q)
      3'd7, 3'd2: begin
        dig   = grp[11:8];
        blank = (grp[11:8] == 4'd0);
      end
      3'd6, 3'd1: begin
        dig   = grp[7:4];
        blank = (grp[11:4] == 8'd0);
      end
      default: dig = grp[3:0];
    endcase
    if (LZ_SUPPRESS == 0) blank = 1'b0;
    cs_d  = 8'hFF;
    sel_d = 8'hFF;
    if (dig_en[idx_q] && disp_on) begin
      sel_d = ~(8'd1 << idx_q);
      cs_d  = dash ? 8'hBF : (blank ? 8'hFF : seg7(dig));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      work_a_q <= '0;
      work_b_q <= '0;
      iter_q   <= '0;
      bcd_a_q  <= '0;
      bcd_b_q  <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      cs_q     <= 8'hFF;
      sel_q    <= 8'hFF;
    end else begin
      state_q  <= state_d;
      work_a_q <= work_a_d;
      work_b_q <= work_b_d;
      iter_q   <= iter_d;
      bcd_a_q  <= bcd_a_d;
      bcd_b_q  <= bcd_b_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      cs_q     <= cs_d;
      sel_q    <= sel_d;
    end
  end

  assign cs        = cs_q;
  assign o_dig_sel = sel_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: two instances (leading-zero blanking on/off) checked
// against a decimal-arithmetic display model on every falling clock edge.
module tb_seg_scan_driver;
  localparam int F_CLK  = 1000;
  localparam int F_SCAN = 100;
  localparam int DIV    = F_CLK / F_SCAN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] val_a = '0, val_b = '0, dig_en = 8'hFF;
  logic       load = 1'b0;
  logic       busy1, busy2;
  logic [7:0] cs1, cs2, sel1, sel2;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  int          disp_a = 0, disp_b = 0;
  int          busy_len = 0;
  logic        prev_busy = 1'b0, prev_load = 1'b0;
  logic [7:0]  prev_en = 8'hFF;
  int          ecnt = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.F_CLK(F_CLK), .F_SCAN(F_SCAN), .LZ_SUPPRESS(1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .val_a(val_a), .val_b(val_b), .load(load), .dig_en(dig_en),
`ifdef SEG_BLINK_EN
    .blink(1'b0),
`endif
    .busy(busy1), .cs(cs1), .o_dig_sel(sel1));

  seg_scan_driver #(.F_CLK(F_CLK), .F_SCAN(F_SCAN), .LZ_SUPPRESS(0)) u_dut_nlz (
    .clk(clk), .rst_n(rst_n), .val_a(val_a), .val_b(val_b), .load(load), .dig_en(dig_en),
`ifdef SEG_BLINK_EN
    .blink(1'b0),
`endif
    .busy(busy2), .cs(cs2), .o_dig_sel(sel2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected {cs, dig_sel} for one slot, from the decimal values on display.
  function automatic logic [15:0] exp_out(input int slot, input int a, input int b,
                                          input logic [7:0] en, input bit lz);
    logic [7:0] sel, code;
    int v, p, d;
    bit blank;
    if (!en[slot]) return 16'hFFFF;
    sel = 8'hFF;
    sel[slot] = 1'b0;
    if (slot == 3 || slot == 4) code = 8'hBF;
    else begin
      v = (slot >= 5) ? a : b;
      p = (slot >= 5) ? slot - 5 : slot;
      d = (p == 2) ? v / 100 : ((p == 1) ? (v / 10) % 10 : v % 10);
      blank = lz && ((p == 2 && v < 100) || (p == 1 && v < 10));
      code = blank ? 8'hFF : seg_of(d);
    end
    return {code, sel};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Monitor: outputs after edge e reflect inputs/display present before edge e.
  always @(negedge clk) begin
    logic [15:0] e1, e2;
    int slot;
    if (!rst_n) begin
      chk("rst_cs", {24'd0, cs1}, 32'hFF);
      chk("rst_sel", {24'd0, sel1}, 32'hFF);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      disp_a = 0;
      disp_b = 0;
      busy_len = 0;
      prev_busy = 1'b0;
    end else begin
      if (ecnt == 0) begin
        e1 = 16'hFFFF;
        e2 = 16'hFFFF;
      end else begin
        slot = ((ecnt - 1) / DIV) % 8;
        e1 = exp_out(slot, disp_a, disp_b, prev_en, 1'b1);
        e2 = exp_out(slot, disp_a, disp_b, prev_en, 1'b0);
      end
      chk("cs_lz", {24'd0, cs1}, {24'd0, e1[15:8]});
      chk("sel_lz", {24'd0, sel1}, {24'd0, e1[7:0]});
      chk("cs_nlz", {24'd0, cs2}, {24'd0, e2[15:8]});
      chk("sel_nlz", {24'd0, sel2}, {24'd0, e2[7:0]});
      if (busy1 && !prev_busy) chk("busy_rise_on_load", {31'd0, prev_load}, 32'd1);
      if (busy1) busy_len++;
      if (!busy1 && prev_busy) begin
        chk("busy_len", busy_len, 8);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL conv_unexpected: got conversion done expected none at %0t", $time);
        end else begin
          logic [15:0] ev;
          ev = exp_q.pop_front();
          disp_a = int'(ev[15:8]);
          disp_b = int'(ev[7:0]);
        end
        busy_len = 0;
      end
      prev_busy = busy1;
    end
    prev_en = dig_en;
    prev_load = load;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int a, input int b, input bit push);
    val_a = 8'(a);
    val_b = 8'(b);
    load = 1'b1;
    if (push) exp_q.push_back({8'(a), 8'(b)});
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(90);

    do_load(255, 7, 1);
    tick(2);
    do_load(1, 2, 0);
    tick(90);

    do_load(42, 100, 1);
    tick(90);
    do_load(3, 5, 1);
    tick(90);

    dig_en = 8'h0F;
    tick(90);
    dig_en = 8'hFF;

    for (int i = 0; i < 12; i++) begin
      int a, b;
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
      b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 255));
      dig_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      do_load(a, b, 1);
      if ($urandom_range(0, 2) == 0) begin
        tick($urandom_range(0, 5));
        do_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
      end
      if ($urandom_range(0, 1) == 1) dig_en = 8'($urandom);
      tick($urandom_range(10, 90));
    end
    dig_en = 8'hFF;

    do_load(9, 200, 1);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy1}, 32'd0);
    chk("async_cs", {24'd0, cs1}, 32'hFF);
    chk("async_sel", {24'd0, sel1}, 32'hFF);
    tick(2);
    exp_q.delete();
    rst_n = 1'b1;
    tick(90);

    chk("queue_drained", exp_q.size(), 0);
    chk("final_busy", {31'd0, busy1}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
